// File: rtl/wishbone_nn_pkg.sv
// Shared definitions for the wishbone_nn master: FSM encoding, width defaults
// and the default NN responder addresses.
package wishbone_nn_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    localparam logic [31:0] NN_IO_ADDR   = 32'h3000_0000;
    localparam logic [31:0] NN_PROG_ADDR = 32'h3000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_t;

endpackage

// File: rtl/wishbone_nn_master_if.sv
// Wishbone B4 classic bus bundle between the wishbone_nn master and a responder.
interface wishbone_nn_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [DATA_W/8-1:0]   wbm_sel_o;
    logic [ADDR_W-1:0]     wbm_adr_o;
    logic [DATA_W-1:0]     wbm_dat_o;
    logic [DATA_W-1:0]     wbm_dat_i;
    logic                  wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts BUS cycles without ack and flags the terminal count.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/wishbone_nn_master.sv
// Wishbone classic single-transfer initiator with cmd/rsp valid-ready ports.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_nn_master
    import wishbone_nn_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    wishbone_nn_master_if.master wbm
);
    wbm_state_t          r_state;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [DATA_W/8-1:0] r_sel;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic                r_rsp_err;

    logic w_accept;
    logic w_ack;
    logic w_timeout;

    assign cmd_ready_o = (r_state == ST_IDLE) && wb_rst_ni;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_ack       = (r_state == ST_BUS) && wbm.wbm_ack_i;

`ifdef WB_MASTER_TIMEOUT_EN
    logic w_expired;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .i_clk     (wb_clk_i),
        .i_rst_n   (wb_rst_ni),
        .i_clear   (w_accept),
        .i_enable  ((r_state == ST_BUS) && !wbm.wbm_ack_i),
        .o_expired (w_expired)
    );

    // An ack on the terminal cycle takes priority over the abort.
    assign w_timeout = (r_state == ST_BUS) && w_expired && !wbm.wbm_ack_i;
`else
    // No watchdog: TIMEOUT_CYCLES is only referenced to keep the parameter list uniform.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_sel   <= cmd_sel_i;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (w_ack) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_we        <= 1'b0;
                        r_rsp_dat   <= r_we ? '0 : wbm.wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_we        <= 1'b0;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_stb;
    assign wbm.wbm_we_o  = r_we;
    assign wbm.wbm_sel_o = r_sel;
    assign wbm.wbm_adr_o = r_adr;
    assign wbm.wbm_dat_o = r_dat;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
endmodule

// File: tb/tb_wishbone_nn_master.sv
// Directed self-checking bench for wishbone_nn_master with a simple B4 slave model.
module tb_wishbone_nn_master;
    import wishbone_nn_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;

    logic          ack_en = 1'b0;
    logic          force_ack = 1'b0;
    int            wait_n = 0;
    int            wcnt = 0;
    logic [DW-1:0] slv_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wishbone_nn_master_if #(.ADDR_W(AW), .DATA_W(DW)) wb ();

    // Slave: acks after wait_n stb cycles; force_ack injects a stray ack.
    always @(posedge clk) begin
        if (wb.wbm_cyc_o && wb.wbm_stb_o) wcnt <= wcnt + 1;
        else                              wcnt <= 0;
    end
    assign wb.wbm_ack_i = force_ack |
                          (ack_en & wb.wbm_cyc_o & wb.wbm_stb_o & (wcnt == wait_n));
    assign wb.wbm_dat_i = slv_rdata;

    wishbone_nn_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm         (wb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [3:0] sel, output logic acc);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        acc       = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, input logic [AW-1:0] adr_exp,
                            output int cyc_n, output int stb_n, output logic stable);
        cyc_n  = 0;
        stb_n  = 0;
        stable = 1'b1;
        while (!rsp_valid && cyc_n < max) begin
            if (wb.wbm_stb_o) stb_n++;
            if (wb.wbm_adr_o !== adr_exp) stable = 1'b0;
            tick();
            cyc_n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_vec++;
        if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctl: cyc/stb/we=%b expected 000",
                              {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o});
        end
        n_vec++;
        if ({wb.wbm_adr_o, wb.wbm_dat_o, wb.wbm_sel_o} !== '0) begin
            n_err++; $display("FAIL reset_bus: adr=%h dat=%h sel=%h expected 0",
                              wb.wbm_adr_o, wb.wbm_dat_o, wb.wbm_sel_o);
        end
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_dat, cmd_ready} !== '0) begin
            n_err++; $display("FAIL reset_rsp: valid=%b err=%b dat=%h ready=%b expected 0",
                              rsp_valid, rsp_err, rsp_dat, cmd_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_comb_ack();
        logic acc, st;
        int c, s;
        ack_en = 1'b1;
        wait_n = 0;
        issue(1'b1, NN_IO_ADDR, 32'hDEAD_BEEF, 4'hF, acc);
        n_vec++;
        if (acc !== 1'b1) begin
            n_err++; $display("FAIL wr_accept: ready=%b expected 1", acc);
        end
        n_vec++;
        if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_dat_o, wb.wbm_sel_o} !==
            {3'b111, 32'hDEAD_BEEF, 4'hF}) begin
            n_err++; $display("FAIL wr_bus: cyc/stb/we=%b dat=%h sel=%h expected 111 deadbeef f",
                              {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}, wb.wbm_dat_o, wb.wbm_sel_o);
        end
        wait_rsp(20, NN_IO_ADDR, c, s, st);
        n_vec++;
        if (c !== 1 || s !== 1) begin
            n_err++; $display("FAIL wr_timing: latency=%0d stb_cycles=%0d expected 1 1", c, s);
        end
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h0}) begin
            n_err++; $display("FAIL wr_rsp: valid=%b err=%b dat=%h expected 1 0 0",
                              rsp_valid, rsp_err, rsp_dat);
        end
        n_vec++;
        if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o} !== 3'b000) begin
            n_err++; $display("FAIL wr_drop: cyc/stb/we=%b expected 000",
                              {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o});
        end
        handshake();
        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_handshake: rsp_valid=%b cmd_ready=%b expected 0 1",
                              rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_wait();
        logic acc, st;
        int c, s;
        ack_en    = 1'b1;
        wait_n    = 3;
        slv_rdata = 32'h1234_5678;
        issue(1'b0, NN_IO_ADDR, 32'h0, 4'hF, acc);
        n_vec++;
        if (wb.wbm_we_o !== 1'b0 || wb.wbm_stb_o !== 1'b1) begin
            n_err++; $display("FAIL rd_bus: we=%b stb=%b expected 0 1", wb.wbm_we_o, wb.wbm_stb_o);
        end
        wait_rsp(20, NN_IO_ADDR, c, s, st);
        n_vec++;
        if (c !== 4 || s !== 4 || st !== 1'b1) begin
            n_err++; $display("FAIL rd_wait: latency=%0d stb_cycles=%0d adr_stable=%b expected 4 4 1",
                              c, s, st);
        end
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h1234_5678}) begin
            n_err++; $display("FAIL rd_rsp: valid=%b err=%b dat=%h expected 1 0 12345678",
                              rsp_valid, rsp_err, rsp_dat);
        end
        n_vec++;
        if (wb.wbm_adr_o !== NN_IO_ADDR || wb.wbm_sel_o !== 4'hF) begin
            n_err++; $display("FAIL rd_retain: adr=%h sel=%h expected 30000000 f",
                              wb.wbm_adr_o, wb.wbm_sel_o);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic acc, st;
        int c, s;
        ack_en    = 1'b1;
        wait_n    = 0;
        slv_rdata = 32'hA5A5_0F0F;
        issue(1'b0, NN_PROG_ADDR, 32'h0, 4'h3, acc);
        wait_rsp(20, NN_PROG_ADDR, c, s, st);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0004;
        cmd_dat   = 32'h1111_2222;
        cmd_sel   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({rsp_valid, rsp_dat, cmd_ready, wb.wbm_cyc_o} !== {1'b1, 32'hA5A5_0F0F, 2'b00}) begin
                n_err++; $display("FAIL bp_hold[%0d]: valid=%b dat=%h cmd_ready=%b cyc=%b expected 1 a5a50f0f 0 0",
                                  i, rsp_valid, rsp_dat, cmd_ready, wb.wbm_cyc_o);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, cmd_ready, wb.wbm_cyc_o} !== 3'b010) begin
            n_err++; $display("FAIL bp_release: valid=%b cmd_ready=%b cyc=%b expected 0 1 0",
                              rsp_valid, cmd_ready, wb.wbm_cyc_o);
        end
        tick();
        cmd_valid = 1'b0;
        n_vec++;
        if ({wb.wbm_cyc_o, wb.wbm_we_o, wb.wbm_adr_o} !== {2'b11, 32'h3000_0004}) begin
            n_err++; $display("FAIL bp_second_cmd: cyc=%b we=%b adr=%h expected 1 1 30000004",
                              wb.wbm_cyc_o, wb.wbm_we_o, wb.wbm_adr_o);
        end
        wait_rsp(20, 32'h3000_0004, c, s, st);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0) begin
            n_err++; $display("FAIL bp_second_rsp: valid=%b dat=%h expected 1 0", rsp_valid, rsp_dat);
        end
        handshake();
    endtask

    task automatic test_spurious_ack();
        logic acc, st;
        int c, s;
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        n_vec++;
        if ({rsp_valid, wb.wbm_cyc_o, cmd_ready} !== 3'b001) begin
            n_err++; $display("FAIL ack_idle: rsp_valid=%b cyc=%b cmd_ready=%b expected 0 0 1",
                              rsp_valid, wb.wbm_cyc_o, cmd_ready);
        end
        ack_en    = 1'b1;
        wait_n    = 1;
        slv_rdata = 32'hCAFE_F00D;
        issue(1'b0, NN_IO_ADDR, 32'h0, 4'hF, acc);
        wait_rsp(20, NN_IO_ADDR, c, s, st);
        slv_rdata = 32'h0BAD_0BAD;
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_dat, wb.wbm_cyc_o} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            n_err++; $display("FAIL ack_resp: valid=%b dat=%h cyc=%b expected 1 cafef00d 0",
                              rsp_valid, rsp_dat, wb.wbm_cyc_o);
        end
        handshake();
        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL ack_after: rsp_valid=%b cmd_ready=%b expected 0 1",
                              rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_bus();
        logic acc, st;
        int c, s;
        ack_en = 1'b0;
        issue(1'b1, NN_IO_ADDR, 32'h55AA_55AA, 4'h3, acc);
        tick();
        tick();
        n_vec++;
        if (wb.wbm_cyc_o !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_pre: cyc=%b expected 1", wb.wbm_cyc_o);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({wb.wbm_cyc_o, wb.wbm_stb_o, cmd_ready, rsp_valid} !== 4'b0000) begin
            n_err++; $display("FAIL rst_mid_async: cyc=%b stb=%b cmd_ready=%b rsp_valid=%b expected 0000",
                              wb.wbm_cyc_o, wb.wbm_stb_o, cmd_ready, rsp_valid);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_release: rsp_valid=%b cmd_ready=%b expected 0 1",
                              rsp_valid, cmd_ready);
        end
        ack_en = 1'b1;
        wait_n = 0;
        issue(1'b1, NN_PROG_ADDR, 32'h0000_0077, 4'h1, acc);
        wait_rsp(20, NN_PROG_ADDR, c, s, st);
        n_vec++;
        if (c !== 1 || {rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h0}) begin
            n_err++; $display("FAIL rst_mid_fresh: latency=%0d valid=%b err=%b dat=%h expected 1 1 0 0",
                              c, rsp_valid, rsp_err, rsp_dat);
        end
        handshake();
    endtask

    task automatic test_timeout();
        logic acc, st;
        int c, s;
        ack_en = 1'b0;
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, acc);
`ifdef WB_MASTER_TIMEOUT_EN
        wait_rsp(40, 32'h3000_0008, c, s, st);
        n_vec++;
        if (c !== TMO || s !== TMO) begin
            n_err++; $display("FAIL tmo_timing: latency=%0d stb_cycles=%0d expected %0d %0d",
                              c, s, TMO, TMO);
        end
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_dat, wb.wbm_cyc_o, wb.wbm_stb_o} !== {2'b11, 32'h0, 2'b00}) begin
            n_err++; $display("FAIL tmo_rsp: valid=%b err=%b dat=%h cyc=%b stb=%b expected 1 1 0 0 0",
                              rsp_valid, rsp_err, rsp_dat, wb.wbm_cyc_o, wb.wbm_stb_o);
        end
        handshake();
        ack_en    = 1'b1;
        wait_n    = 0;
        slv_rdata = 32'h0000_00C3;
        issue(1'b0, NN_IO_ADDR, 32'h0, 4'hF, acc);
        wait_rsp(20, NN_IO_ADDR, c, s, st);
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h0000_00C3}) begin
            n_err++; $display("FAIL tmo_recover: valid=%b err=%b dat=%h expected 1 0 000000c3",
                              rsp_valid, rsp_err, rsp_dat);
        end
        handshake();
`else
        wait_rsp(100, 32'h3000_0008, c, s, st);
        n_vec++;
        if ({rsp_valid, wb.wbm_cyc_o, wb.wbm_stb_o, rsp_err} !== 4'b0110) begin
            n_err++; $display("FAIL notmo_wait: rsp_valid=%b cyc=%b stb=%b err=%b expected 0 1 1 0",
                              rsp_valid, wb.wbm_cyc_o, wb.wbm_stb_o, rsp_err);
        end
        n_vec++;
        if (s !== 100) begin
            n_err++; $display("FAIL notmo_stb: stb_cycles=%0d expected 100", s);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_comb_ack();
        test_read_wait();
        test_backpressure();
        test_spurious_ack();
        test_reset_mid_bus();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wishbone_nn_master.md
Name: wishbone_nn_master

Overview:
Wishbone classic single-transfer initiator. Accepts read/write commands on a valid/ready command port, runs one registered Wishbone cycle per command against the wishbone_nn responder (or any B4 classic slave), and returns read data and status on a valid/ready response port. Used by test harnesses and future on-chip sequencers to load input words into the NN FIFO and read results back.

Parameters:
ADDR_W, 32, Wishbone address width
DATA_W, 32, Wishbone data width; sel width = DATA_W/8
TIMEOUT_CYCLES, 16, BUS-state cycles without ack before abort (>=2; used only with WB_MASTER_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  ADDR_W  target address
cmd_dat_i  in  DATA_W  write data
cmd_sel_i  in  DATA_W/8  byte selects
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  DATA_W  read data (0 for writes and errors)
rsp_err_o  out  1  transfer aborted by timeout
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  DATA_W/8  Wishbone byte selects
wbm_adr_o  out  ADDR_W  Wishbone address
wbm_dat_o  out  DATA_W  Wishbone write data
wbm_dat_i  in  DATA_W  Wishbone read data
wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (async, wb_rst_ni low): state IDLE; all wbm_* outputs 0; rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0; cmd_ready_o=0 while in reset. Reset mid-transfer drops cyc/stb immediately; the command is lost and no response is issued.
- All wbm_* and rsp_* outputs are registered. cmd_ready_o = (state==IDLE).
- FSM IDLE -> BUS -> RESP -> IDLE:
  - IDLE: on cmd_valid_i&cmd_ready_o, latch we/adr/dat/sel into wbm_* and set cyc=stb=1; go BUS.
  - BUS: cyc/stb held, inputs stable. At the first rising edge with wbm_ack_i=1: clear cyc/stb/we; rsp_dat_o <= (read ? wbm_dat_i : 0); rsp_err_o<=0; rsp_valid_o<=1; go RESP. Same-cycle (combinational) ack is supported, giving one stb cycle per transfer.
  - RESP: hold rsp_* until rsp_valid_o&rsp_ready_i; then rsp_valid_o<=0 and go IDLE. Backpressure is unbounded.
- Minimum throughput: 3 cycles per command (accept, bus, response handshake). Latency from command accept to rsp_valid_o is 2 cycles with zero-wait ack.
- wbm_ack_i outside BUS is ignored. Commands offered outside IDLE are not accepted (cmd_ready_o=0).
- wbm_adr_o/wbm_dat_o/wbm_sel_o retain their last values after a transfer; only cyc/stb/we are cleared.

Optional Feature:
WB_MASTER_TIMEOUT_EN: defined -> a counter of width clog2(TIMEOUT_CYCLES)+1 clears on entry to BUS and increments each BUS cycle without ack. When count==TIMEOUT_CYCLES-1 with no ack: drop cyc/stb, rsp_err_o<=1, rsp_dat_o<=0, rsp_valid_o<=1, go RESP. An ack on the terminal cycle wins (normal response). Undefined -> no counter; BUS waits indefinitely; rsp_err_o is tied 0.

Decomposition:
- Package wishbone_nn_pkg: FSM state encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2), default address constants NN_IO_ADDR=32'h30000000 and NN_PROG_ADDR=32'h30000001, and the width defaults.
- One sub-module: wb_timeout_ctr (clear/enable/expired), instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Write 0xDEADBEEF to 0x30000000, sel=4'hF, slave model with combinational ack -> stb high exactly 1 cycle, wbm_we_o=1, rsp_valid_o 2 cycles after accept, rsp_dat_o=0, rsp_err_o=0.
- Read 0x30000000, slave returns 0x12345678 after 3 wait cycles -> stb held 4 cycles, rsp_dat_o=0x12345678, wbm_adr_o stable throughout.
- With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, read 0x30000008 with no ack -> cyc/stb drop after 16 BUS cycles, rsp_err_o=1, rsp_dat_o=0. Without the macro -> still waiting after 100 cycles.
- Hold rsp_ready_i=0 for 5 cycles after response -> rsp_* stable, cmd_ready_o=0; a second command is accepted only in the cycle after the handshake.
- Assert wb_rst_ni low mid-BUS -> wbm_cyc_o/stb_o go 0 asynchronously, no rsp_valid_o; after release, a fresh write completes normally.
- Pulse wbm_ack_i in IDLE and RESP -> no state change, no spurious response.
